// File: rtl/qie_sr_loader.sv
// qie_sr_loader: serial configuration engine for the twelve QIE10 chips.
// Shifts a parallel word into one chip MSB first (write + load), recirculates
// a chip's register for readback (read), or pulses the shared chip reset.
// Bits shifted out of the selected chip are collected in RdData.
module qie_sr_loader #(
  parameter int SR_LEN  = 96,
  parameter int CLK_DIV = 4
) (
  input  logic              MClk,
  input  logic              BkPln_RST,
  input  logic              Start,
  input  logic [1:0]        Cmd,
  input  logic [3:0]        ChipSel,
  input  logic [SR_LEN-1:0] WrData,
  output logic [SR_LEN-1:0] RdData,
  output logic              Busy,
  output logic              Done,
  output logic              Err,
  output logic              QieAll_SRin,
  output logic              QieAll_SRreset,
  output logic              QieAll_SRread,
  output logic [11:0]       Qie_SRck,
  output logic [11:0]       Qie_SRload,
  input  logic [11:0]       Qie_SRout
);
  localparam int NCHIP = 12;
  localparam int PER   = 2 * CLK_DIV;
  localparam int DW    = (PER > 1) ? $clog2(PER) : 1;
  localparam int BW    = (SR_LEN > 1) ? $clog2(SR_LEN) : 1;
  localparam logic [DW-1:0] PH_RISE  = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] PH_LAST  = DW'(PER - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(SR_LEN - 1);

  typedef enum logic [2:0] {IDLE, SHIFT, LOAD, CRST, FIN} state_t;

  state_t            state;
  logic [DW-1:0]     div_cnt;
  logic [BW-1:0]     bit_cnt;
  logic              rd_mode;
  logic [3:0]        sel_q;
  logic [SR_LEN-1:0] wr_sh;

  logic              cmd_ok;
  logic [NCHIP-1:0]  sel_oh;   // latched chip, one-hot
  logic [NCHIP-1:0]  in_oh;    // chip on the ChipSel input, one-hot
  logic              sr_bit;   // selected chip's SRout
  logic              in_bit;   // SRout of the chip being started

  assign cmd_ok = (Cmd != 2'd3) && (ChipSel >= 4'd1) && (ChipSel <= 4'd12);

  for (genvar g = 0; g < NCHIP; g++) begin : g_dec
    assign sel_oh[g] = (sel_q   == 4'(g + 1));
    assign in_oh[g]  = (ChipSel == 4'(g + 1));
  end

  // AND-OR select avoids an out-of-range index when sel_q is 0
  assign sr_bit = |(Qie_SRout & sel_oh);
  assign in_bit = |(Qie_SRout & in_oh);

  // Command FSM; every output is registered
  always_ff @(posedge MClk) begin
    if (BkPln_RST) begin
      state          <= IDLE;
      div_cnt        <= '0;
      bit_cnt        <= '0;
      rd_mode        <= 1'b0;
      sel_q          <= '0;
      wr_sh          <= '0;
      RdData         <= '0;
      Busy           <= 1'b0;
      Done           <= 1'b0;
      Err            <= 1'b0;
      QieAll_SRin    <= 1'b0;
      QieAll_SRreset <= 1'b0;
      QieAll_SRread  <= 1'b0;
      Qie_SRck       <= '0;
      Qie_SRload     <= '0;
    end else begin
      Done <= 1'b0;
      Err  <= 1'b0;
      case (state)
        IDLE: if (Start) begin
          sel_q   <= ChipSel;
          rd_mode <= (Cmd == 2'd1);
          div_cnt <= '0;
          bit_cnt <= '0;
          if (!cmd_ok) begin
            state <= FIN;
            Done  <= 1'b1;
            Err   <= 1'b1;
          end else if (Cmd == 2'd2) begin
            state          <= CRST;
            Busy           <= 1'b1;
            QieAll_SRreset <= 1'b1;
          end else begin
            state         <= SHIFT;
            Busy          <= 1'b1;
            RdData        <= '0;
            wr_sh         <= WrData << 1;
            // read recirculates: the chip's SRout at bit start is the bit it is
            // about to shift out, so feeding it back keeps the contents intact
            QieAll_SRin   <= (Cmd == 2'd1) ? in_bit : WrData[SR_LEN-1];
            QieAll_SRread <= (Cmd == 2'd1);
          end
        end
        SHIFT: begin
          div_cnt <= div_cnt + 1'b1;
          if (div_cnt == PH_RISE) begin
            Qie_SRck <= sel_oh;
            RdData   <= {RdData[SR_LEN-2:0], sr_bit};
          end
          if (div_cnt == PH_LAST) begin
            div_cnt  <= '0;
            Qie_SRck <= '0;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt       <= '0;
              QieAll_SRin   <= 1'b0;
              QieAll_SRread <= 1'b0;
              if (rd_mode) begin
                state <= FIN;
                Busy  <= 1'b0;
                Done  <= 1'b1;
              end else begin
                state      <= LOAD;
                Qie_SRload <= sel_oh;
              end
            end else begin
              bit_cnt     <= bit_cnt + 1'b1;
              QieAll_SRin <= rd_mode ? sr_bit : wr_sh[SR_LEN-1];
              wr_sh       <= wr_sh << 1;
            end
          end
        end
        LOAD: begin
          div_cnt <= div_cnt + 1'b1;
          if (div_cnt == PH_LAST) begin
            div_cnt    <= '0;
            Qie_SRload <= '0;
            state      <= FIN;
            Busy       <= 1'b0;
            Done       <= 1'b1;
          end
        end
        CRST: begin
          div_cnt <= div_cnt + 1'b1;
          if (div_cnt == PH_LAST) begin
            div_cnt        <= '0;
            QieAll_SRreset <= 1'b0;
            state          <= FIN;
            Busy           <= 1'b0;
            Done           <= 1'b1;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_qie_sr_loader.sv
// Bench for qie_sr_loader: behavioural QIE chips, a transaction-level model of
// the expected pin waveforms checked every cycle, and directed scenarios.
module tb_qie_sr_loader;
  localparam int N  = 96;
  localparam int CD = 4;
  localparam int P  = 2 * CD;

  logic         MClk = 1'b0;
  logic         BkPln_RST = 1'b1;
  logic         Start = 1'b0;
  logic [1:0]   Cmd = '0;
  logic [3:0]   ChipSel = '0;
  logic [N-1:0] WrData = '0;
  logic [N-1:0] RdData;
  logic         Busy, Done, Err, QieAll_SRin, QieAll_SRreset, QieAll_SRread;
  logic [11:0]  Qie_SRck, Qie_SRload, Qie_SRout;

  qie_sr_loader #(.SR_LEN(N), .CLK_DIV(CD)) dut (
    .MClk(MClk), .BkPln_RST(BkPln_RST), .Start(Start), .Cmd(Cmd),
    .ChipSel(ChipSel), .WrData(WrData), .RdData(RdData), .Busy(Busy),
    .Done(Done), .Err(Err), .QieAll_SRin(QieAll_SRin),
    .QieAll_SRreset(QieAll_SRreset), .QieAll_SRread(QieAll_SRread),
    .Qie_SRck(Qie_SRck), .Qie_SRload(Qie_SRload), .Qie_SRout(Qie_SRout));

  always #5 MClk = ~MClk;

  // ---------------- behavioural QIE chips ----------------
  logic [N-1:0] chip_sr[12]  = '{default: '0};
  logic [N-1:0] chip_cfg[12] = '{default: '0};
  logic [11:0]  ck_prev = '0, ld_prev = '0;
  logic         rs_prev = 1'b0;
  logic         pl_en = 1'b0;
  int           pl_idx = 0;
  logic [N-1:0] pl_val = '0;

  for (genvar g = 0; g < 12; g++) begin : g_out
    assign Qie_SRout[g] = chip_sr[g][N-1];
  end

  always @(posedge MClk) begin
    ck_prev <= Qie_SRck;
    ld_prev <= Qie_SRload;
    rs_prev <= QieAll_SRreset;
    for (int i = 0; i < 12; i++) begin
      if (pl_en && pl_idx == i) chip_sr[i] <= pl_val;
      else if (QieAll_SRreset && !rs_prev) begin
        chip_sr[i]  <= '0;
        chip_cfg[i] <= '0;
      end else begin
        if (Qie_SRck[i] && !ck_prev[i])   chip_sr[i]  <= {chip_sr[i][N-2:0], QieAll_SRin};
        if (Qie_SRload[i] && !ld_prev[i]) chip_cfg[i] <= chip_sr[i];
      end
    end
  end

  // ---------------- cumulative pin monitor ----------------
  int           ck_rise[12] = '{default: 0};
  int           load_hi[12] = '{default: 0};
  int           rst_hi = 0, rd_hi = 0, done_cnt = 0, busy_hi = 0, qie_act = 0;
  logic [N-1:0] srin_hist = '0;
  logic [11:0]  mck_prev = '0;

  always @(negedge MClk) begin
    for (int i = 0; i < 12; i++) begin
      if (Qie_SRck[i] && !mck_prev[i]) ck_rise[i] <= ck_rise[i] + 1;
      if (Qie_SRload[i]) load_hi[i] <= load_hi[i] + 1;
    end
    if (Qie_SRck[2] && !mck_prev[2]) srin_hist <= {srin_hist[N-2:0], QieAll_SRin};
    if (QieAll_SRreset) rst_hi <= rst_hi + 1;
    if (QieAll_SRread)  rd_hi <= rd_hi + 1;
    if (Done)           done_cnt <= done_cnt + 1;
    if (Busy)           busy_hi <= busy_hi + 1;
    if (|Qie_SRck || |Qie_SRload || QieAll_SRreset || QieAll_SRread) qie_act <= qie_act + 1;
    mck_prev <= Qie_SRck;
  end

  // ---------------- transaction model ----------------
  // kind: 0 write, 1 read, 2 chip reset, 3 rejected command
  int           cyc = 0, k_m = 0, dur = 0, last_end = -1;
  logic         active = 1'b0, rst_q = 1'b0, seen_rst = 1'b0;
  logic [1:0]   kind = '0;
  logic [11:0]  oh_m = '0;
  logic [N-1:0] wd = '0, snap = '0, held = '0;
  logic         cmd_ok;

  assign cmd_ok = (Cmd != 2'd3) && (ChipSel >= 4'd1) && (ChipSel <= 4'd12);

  always @(posedge MClk) begin
    cyc   <= cyc + 1;
    rst_q <= BkPln_RST;
    if (BkPln_RST) begin
      active   <= 1'b0;
      held     <= '0;
      last_end <= cyc;
      seen_rst <= 1'b1;
    end else begin
      if (active && cyc >= k_m + dur) begin
        active <= 1'b0;
        if (kind <= 2'd1) held <= snap;
      end
      if (Start && cyc > last_end) begin
        active   <= 1'b1;
        k_m      <= cyc;
        kind     <= cmd_ok ? Cmd : 2'd3;
        dur      <= !cmd_ok ? 1 : (Cmd == 2'd0) ? N*P + P + 1 : (Cmd == 2'd1) ? N*P + 1 : P + 1;
        last_end <= cyc + (!cmd_ok ? 1 : (Cmd == 2'd0) ? N*P + P + 1 : (Cmd == 2'd1) ? N*P + 1 : P + 1);
        oh_m     <= 12'd1 << (ChipSel - 4'd1);
        wd       <= WrData;
        snap     <= (cmd_ok && Cmd != 2'd2) ? chip_sr[ChipSel - 4'd1] : '0;
      end
    end
  end

  int checks = 0, errors = 0, cmp_checks = 0, cmp_errors = 0;

  // per-cycle compare of every output against the model
  initial forever begin
    logic [29:0]  ex, ac, mk;
    logic [N-1:0] er;
    int           t, b, ph, nc;
    logic         shf;
    @(negedge MClk);
    if (seen_rst) begin
      ex = '0; mk = '1; er = held; shf = 1'b0;
      if (!rst_q && active) begin
        t = cyc - k_m;
        if (kind <= 2'd1 && t >= 1 && t <= N*P) begin
          b = (t - 1) / P; ph = (t - 1) % P; shf = 1'b1;
          nc = b + ((ph >= CD) ? 1 : 0);
          ex[29] = 1'b1;
          ex[26] = (kind == 2'd1) ? snap[N-1-b] : wd[N-1-b];
          ex[24] = (kind == 2'd1);
          if (ph >= CD) ex[23:12] = oh_m;
          er = snap >> (N - nc);
        end else if (kind == 2'd0 && t > N*P && t <= N*P + P) begin
          ex[29] = 1'b1; ex[11:0] = oh_m; er = snap;
        end else if (t == dur) begin
          ex[28] = 1'b1; ex[27] = (kind == 2'd3);
          if (kind <= 2'd1) er = snap;
        end else if (kind == 2'd2 && t >= 1 && t <= P) begin
          ex[29] = 1'b1; ex[25] = 1'b1;
        end
      end
      if (!shf && !rst_q) mk[26] = 1'b0;  // SRin is only defined while shifting
      ac = {Busy, Done, Err, QieAll_SRin, QieAll_SRreset, QieAll_SRread, Qie_SRck, Qie_SRload};
      cmp_checks = cmp_checks + 2;
      if ((ac & mk) !== (ex & mk)) begin
        cmp_errors++;
        $display("FAIL pins cyc=%0d actual=%h required=%h", cyc, ac & mk, ex & mk);
      end
      if (RdData !== er) begin
        cmp_errors++;
        $display("FAIL rddata cyc=%0d actual=%h required=%h", cyc, RdData, er);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, a, e);
    end
  endtask

  task automatic preload(input int idx, input logic [N-1:0] v);
    @(negedge MClk); pl_en = 1'b1; pl_idx = idx; pl_val = v;
    @(negedge MClk); pl_en = 1'b0;
  endtask

  task automatic issue(input logic [1:0] c, input logic [3:0] s, input logic [N-1:0] d, output int kk);
    @(negedge MClk);
    Start = 1'b1; Cmd = c; ChipSel = s; WrData = d; kk = cyc;
    @(negedge MClk);
    Start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int at, output logic e);
    at = -1; e = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (Done) begin at = cyc; e = Err; break; end
      @(negedge MClk);
    end
  endtask

  localparam logic [N-1:0] PAT_A5 = {12{8'hA5}};
  localparam logic [N-1:0] PAT_0F = {12{8'h0F}};
  localparam logic [N-1:0] PAT_RD = 96'h123456789ABCDEF012345678;
  localparam logic [N-1:0] PAT_D1 = 96'hDEADBEEF_CAFEF00D_01234567;
  localparam logic [N-1:0] PAT_D2 = 96'h5A5A_0000_FFFF_1234_8001_7E7E;

  initial begin
    int k, kd, at, s, ld0[12], ck0[12], rh0, rd0, dn0, bz0, qa0;
    logic ef;
    repeat (3) @(negedge MClk);
    chk("reset_outputs", {Busy, Done, Err, QieAll_SRin, QieAll_SRreset, QieAll_SRread,
                          Qie_SRck, Qie_SRload, RdData}, '0);
    BkPln_RST = 1'b0;
    preload(2, PAT_0F);
    preload(11, PAT_RD);

    // write A5.. to chip 3
    ck0 = ck_rise; ld0 = load_hi;
    issue(2'd0, 4'd3, PAT_A5, k);
    wait_done(1000, at, ef);
    repeat (3) @(negedge MClk);
    chk("wr_done_latency", at - k, 777);
    chk("wr_ck_rises_chip3", ck_rise[2] - ck0[2], 96);
    s = 0;
    for (int i = 0; i < 12; i++) if (i != 2) s += (ck_rise[i] - ck0[i]) + (load_hi[i] - ld0[i]);
    chk("wr_other_chips_quiet", s, 0);
    chk("wr_srin_first8", srin_hist[N-1:N-8], 8'b1010_0101);
    chk("wr_srin_all", srin_hist, PAT_A5);
    chk("wr_load_cycles", load_hi[2] - ld0[2], 8);
    chk("wr_rddata", RdData, PAT_0F);
    chk("wr_chip_cfg", chip_cfg[2], PAT_A5);
    chk("wr_chip_sr", chip_sr[2], PAT_A5);

    // read chip 12
    ld0 = load_hi; rd0 = rd_hi;
    issue(2'd1, 4'd12, '0, k);
    wait_done(1000, at, ef);
    repeat (3) @(negedge MClk);
    chk("rd_done_latency", at - k, 769);
    chk("rd_srread_cycles", rd_hi - rd0, 768);
    s = 0;
    for (int i = 0; i < 12; i++) s += load_hi[i] - ld0[i];
    chk("rd_no_load", s, 0);
    chk("rd_rddata", RdData, PAT_RD);
    chk("rd_chip_unchanged", chip_sr[11], PAT_RD);

    // rejected commands: bad chip, then bad command
    for (int j = 0; j < 2; j++) begin
      qa0 = qie_act; bz0 = busy_hi;
      issue((j == 0) ? 2'd0 : 2'd3, (j == 0) ? 4'd13 : 4'd5, PAT_A5, k);
      wait_done(5, at, ef);
      repeat (3) @(negedge MClk);
      chk("err_done_latency", at - k, 1);
      chk("err_flag", ef, 1'b1);
      chk("err_busy_low", busy_hi - bz0, 0);
      chk("err_qie_quiet", qie_act - qa0, 0);
      chk("err_rddata_held", RdData, PAT_RD);
    end

    // chip reset
    rh0 = rst_hi;
    issue(2'd2, 4'd1, '0, k);
    wait_done(50, at, ef);
    repeat (3) @(negedge MClk);
    chk("crst_done_latency", at - k, 9);
    chk("crst_high_cycles", rst_hi - rh0, 8);

    // backplane reset in the middle of a write (bit 40)
    dn0 = done_cnt; ld0 = load_hi;
    issue(2'd0, 4'd5, PAT_D1, k);
    while (cyc < k + 1 + 40 * P) @(negedge MClk);
    BkPln_RST = 1'b1;
    @(negedge MClk);
    BkPln_RST = 1'b0;
    chk("abort_outputs", {Busy, Done, Err, QieAll_SRin, QieAll_SRreset, QieAll_SRread,
                          Qie_SRck, Qie_SRload, RdData}, '0);
    repeat (900) @(negedge MClk);
    chk("abort_no_done", done_cnt - dn0, 0);
    chk("abort_no_load", load_hi[4] - ld0[4], 0);
    chk("abort_cfg_untouched", chip_cfg[4], '0);
    issue(2'd0, 4'd5, PAT_D1, k);
    wait_done(1000, at, ef);
    repeat (3) @(negedge MClk);
    chk("after_abort_latency", at - k, 777);
    chk("after_abort_cfg", chip_cfg[4], PAT_D1);

    // Start while busy is ignored
    dn0 = done_cnt; rh0 = rst_hi;
    issue(2'd0, 4'd1, PAT_D2, k);
    repeat (100) @(negedge MClk);
    issue(2'd2, 4'd7, '0, kd);
    wait_done(1000, at, ef);
    repeat (20) @(negedge MClk);
    chk("busy_start_latency", at - k, 777);
    chk("busy_start_one_done", done_cnt - dn0, 1);
    chk("busy_start_no_reset", rst_hi - rh0, 0);
    chk("busy_start_cfg", chip_cfg[0], PAT_D2);

    checks = checks + cmp_checks;
    errors = errors + cmp_errors;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/qie_sr_loader.md
# qie_sr_loader

Serial configuration engine for the twelve QIE10 ASICs on the HF readout module. It takes a parallel configuration word and a chip select from the slow-control register file (RBXbus side), then drives the shared QieAll_SRin/SRreset/SRread lines and the per-chip SRck/SRload lines. It captures the bits shifted out on Qie*_SRout for readback. It sits between the slow-control decoder and the QIE control pins of the top level.

## Interface
- SR_LEN, 96: bits in one QIE10 shift register.
- CLK_DIV, 4: MClk cycles per SRck half-period (≥1). One bit period is 2·CLK_DIV.

Ports:
- MClk  in  1  master clock; everything is synchronous to its rising edge.
- BkPln_RST  in  1  reset, synchronous and active-high.
- Start  in  1  single-cycle command strobe; sampled only in IDLE.
- Cmd  in  2  command: 0 = write (shift + load), 1 = read (recirculating shift), 2 = chip reset. Value 3 is an error.
- ChipSel  in  4  target chip, 1..12; 0 and 13..15 are errors.
- WrData  in  SR_LEN  configuration word, sent MSB first; latched at Start.
- RdData  out  SR_LEN  bits shifted out of the chip; the first captured bit lands in the MSB.
- Busy  out  1  high while a command is in progress.
- Done  out  1  one-cycle pulse at the end of every accepted Start.
- Err  out  1  one-cycle pulse together with Done when Cmd or ChipSel is invalid.
- QieAll_SRin, QieAll_SRreset, QieAll_SRread  out  1 each  shared QIE control lines.
- Qie_SRck, Qie_SRload  out  12 each  per-chip clock and load; bit n-1 drives chip n.
- Qie_SRout  in  12  per-chip serial out.

## Operation
- Reset values:
  - All outputs are 0, including RdData and all Qie lines.
  - State is IDLE.
  - Internal counters are 0.
- States: IDLE, SHIFT, LOAD, CRST, FIN.
- IDLE: on Start, latch Cmd, ChipSel and WrData.
  - Invalid Cmd or ChipSel: go to FIN with Err set. No Qie line toggles.
  - Cmd 0 or 1: go to SHIFT, bit counter = 0.
  - Cmd 2: go to CRST.
- SHIFT, per bit:
  - First CLK_DIV cycles: SRck low.
  - Next CLK_DIV cycles: SRck high, on the selected chip only.
  - SRin changes only on the cycle SRck is driven low, i.e. at the start of each bit.
  - Write: SRin = WrData[SR_LEN-1-i].
  - Read: SRin = the bit captured from Qie_SRout[ChipSel-1] on the previous bit (bit 0 uses the chip's current SRout), so chip contents are preserved. QieAll_SRread is held high for the whole SHIFT.
  - Capture: on the last low cycle of each bit, Qie_SRout[ChipSel-1] shifts into RdData from the LSB side. After SR_LEN bits the first captured bit is in the MSB.
  - After SR_LEN bits: write goes to LOAD, read goes to FIN.
- LOAD: Qie_SRload[ChipSel-1] is high for 2·CLK_DIV cycles, SRck is low, then go to FIN.
- CRST: QieAll_SRreset is high for 2·CLK_DIV cycles (all chips), then go to FIN.
- FIN: one cycle with Done=1 (and Err if flagged), then IDLE.
- Start while Busy is ignored, with no queueing.
- BkPln_RST at any time: on the next edge all outputs return to reset values. RdData is cleared, a partial shift is abandoned, and no Done is issued.
- RdData is held until the next accepted read or write Start. It is cleared at that Start.

## Timing
- Start sampled at edge k → Busy=1 from cycle k+1. Busy falls in the same cycle Done rises.
- Write: Done at cycle k+1+(SR_LEN+1)·2·CLK_DIV. Defaults give k+777.
- Read: Done at k+1+SR_LEN·2·CLK_DIV. Defaults give k+769.
- Chip reset: Done at k+1+2·CLK_DIV. Defaults give k+9.
- Error: Done and Err at k+1, Busy never asserted.
- SRin setup to SRck rise is CLK_DIV cycles; hold is CLK_DIV cycles.
- Unselected chips' SRck and SRload stay 0 throughout.

## Test plan
- Write 0xA5…A5 (96 bits) to chip 3 with a behavioural QIE model preloaded with 0x0F…0F. Required:
  - exactly 96 SRck rises, on bit 2 only;
  - SRin sequence 1,0,1,0,0,1,0,1,…;
  - SRload[2] high for 8 cycles;
  - Done at k+777;
  - RdData = 0x0F…0F;
  - model contents = 0xA5…A5.
- Read chip 12 holding 0x123…: QieAll_SRread high throughout, no SRload, Done at k+769, RdData = 0x123…, model contents unchanged.
- Start with ChipSel=13, then Cmd=3: each gives Done+Err at k+1, Busy stays 0, no Qie line toggles.
- Cmd=2: QieAll_SRreset high for exactly 8 cycles, Done at k+9.
- Assert BkPln_RST at bit 40 of a write: next cycle all outputs and RdData are 0, no Done, and the model is never loaded. A new Start afterwards completes normally.
- Pulse Start during a write in progress: it is ignored, and only one Done is issued, at k+777.
